dual_issue_scoreboard: RTL and testbench

- Per-register in-flight producer tracker for the dual-issue RV32I pipeline.
- Marks registers busy and load-pending when slot0/slot1 issue a register write.
- Clears those marks when the matching producer's load data becomes forwardable or its writeback commits.
- Drives the busy_vec / load_pending_vec view consumed by the issue logic; tags make out-of-order clears from superseded (WAW) producers harmless.

---
 rtl/dual_issue_scoreboard.sv | 89 ++++++++
 tb/tb_dual_issue_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: per-register busy/load-pending tracker with WAW-safe producer tags
module dual_issue_scoreboard #(
    parameter int TAG_W = 3,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iss0_valid,
    input  logic [4:0]       iss0_rd,
    input  logic             iss0_is_load,
    output logic [TAG_W-1:0] iss0_tag,
    input  logic             iss1_valid,
    input  logic [4:0]       iss1_rd,
    input  logic             iss1_is_load,
    output logic [TAG_W-1:0] iss1_tag,
    input  logic             wb0_valid,
    input  logic [4:0]       wb0_rd,
    input  logic [TAG_W-1:0] wb0_tag,
    input  logic             wb1_valid,
    input  logic [4:0]       wb1_rd,
    input  logic [TAG_W-1:0] wb1_tag,
    input  logic             ld_rdy_valid,
    input  logic [4:0]       ld_rdy_rd,
    input  logic [TAG_W-1:0] ld_rdy_tag,
    output logic [NREG-1:0]  busy_vec,
    output logic [NREG-1:0]  load_pending_vec,
    output logic [5:0]       busy_count
);
    logic [NREG-1:0]  busy_q, busy_d, ldp_q, ldp_d;
    logic [TAG_W-1:0] last_tag_q [NREG];
    logic [TAG_W-1:0] last_tag_d [NREG];
    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    assign iss0_tag         = next_tag_q;
    assign iss1_tag         = next_tag_q + TAG_W'(iss0_valid);
    assign busy_vec         = busy_q;
    assign load_pending_vec = ldp_q;
    always_comb begin
        busy_d     = busy_q;
        ldp_d      = ldp_q;
        last_tag_d = last_tag_q;
        next_tag_d = next_tag_q + TAG_W'(iss0_valid) + TAG_W'(iss1_valid);
        if (ld_rdy_valid && ld_rdy_rd != 5'd0 && busy_q[ld_rdy_rd] && ldp_q[ld_rdy_rd] &&
            last_tag_q[ld_rdy_rd] == ld_rdy_tag)
            ldp_d[ld_rdy_rd] = 1'b0;
        if (wb0_valid && wb0_rd != 5'd0 && busy_q[wb0_rd] && last_tag_q[wb0_rd] == wb0_tag) begin
            busy_d[wb0_rd] = 1'b0;
            ldp_d[wb0_rd]  = 1'b0;
        end
        if (wb1_valid && wb1_rd != 5'd0 && busy_q[wb1_rd] && last_tag_q[wb1_rd] == wb1_tag) begin
            busy_d[wb1_rd] = 1'b0;
            ldp_d[wb1_rd]  = 1'b0;
        end
        if (iss0_valid && iss0_rd != 5'd0) begin
            busy_d[iss0_rd]     = 1'b1;
            ldp_d[iss0_rd]      = iss0_is_load;
            last_tag_d[iss0_rd] = iss0_tag;
        end
        if (iss1_valid && iss1_rd != 5'd0) begin
            busy_d[iss1_rd]     = 1'b1;
            ldp_d[iss1_rd]      = iss1_is_load;
            last_tag_d[iss1_rd] = iss1_tag;
        end
        // next_tag survives flush so draining writebacks cannot alias a fresh producer
        if (flush) begin
            busy_d     = '0;
            ldp_d      = '0;
            last_tag_d = last_tag_q;
            next_tag_d = next_tag_q;
        end
    end
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NREG; i++) busy_count = busy_count + 6'(busy_q[i]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            ldp_q      <= '0;
            next_tag_q <= '0;
            last_tag_q <= '{default: '0};
        end else begin
            busy_q     <= busy_d;
            ldp_q      <= ldp_d;
            next_tag_q <= next_tag_d;
            last_tag_q <= last_tag_d;
        end
    end
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: directed literal checks plus randomized run against a register-table model
module tb_dual_issue_scoreboard;
    localparam int TAG_W = 3;
    localparam int NT    = 8;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic iss0_valid = 1'b0, iss0_is_load = 1'b0, iss1_valid = 1'b0, iss1_is_load = 1'b0;
    logic [4:0] iss0_rd = '0, iss1_rd = '0, wb0_rd = '0, wb1_rd = '0, ld_rdy_rd = '0;
    logic wb0_valid = 1'b0, wb1_valid = 1'b0, ld_rdy_valid = 1'b0;
    logic [TAG_W-1:0] wb0_tag = '0, wb1_tag = '0, ld_rdy_tag = '0;
    logic [TAG_W-1:0] iss0_tag, iss1_tag;
    logic [31:0] busy_vec, load_pending_vec;
    logic [5:0] busy_count;
    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;
    bit [31:0] m_busy = '0, m_ldp = '0;
    int m_tag [32];
    int m_next = 0;

    dual_issue_scoreboard #(.TAG_W(TAG_W), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .iss0_valid(iss0_valid), .iss0_rd(iss0_rd), .iss0_is_load(iss0_is_load), .iss0_tag(iss0_tag),
        .iss1_valid(iss1_valid), .iss1_rd(iss1_rd), .iss1_is_load(iss1_is_load), .iss1_tag(iss1_tag),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_tag(wb0_tag),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_tag(wb1_tag),
        .ld_rdy_valid(ld_rdy_valid), .ld_rdy_rd(ld_rdy_rd), .ld_rdy_tag(ld_rdy_tag),
        .busy_vec(busy_vec), .load_pending_vec(load_pending_vec), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event-by-event application of the register table: clears judged on the old table,
    // later events in priority order overwrite earlier ones.
    task automatic model_step();
        bit [31:0] ob = m_busy, ol = m_ldp;
        int ot [32];
        int t0, t1;
        foreach (m_tag[i]) ot[i] = m_tag[i];
        t0 = m_next;
        t1 = (m_next + int'(iss0_valid)) % NT;
        if (!rst_n) begin
            m_busy = '0; m_ldp = '0; m_next = 0;
            foreach (m_tag[i]) m_tag[i] = 0;
        end else if (flush) begin
            m_busy = '0; m_ldp = '0;
        end else begin
            if (ld_rdy_valid && ld_rdy_rd != 0 && ob[ld_rdy_rd] && ol[ld_rdy_rd] && ot[ld_rdy_rd] == int'(ld_rdy_tag))
                m_ldp[ld_rdy_rd] = 1'b0;
            if (wb0_valid && wb0_rd != 0 && ob[wb0_rd] && ot[wb0_rd] == int'(wb0_tag)) begin
                m_busy[wb0_rd] = 1'b0; m_ldp[wb0_rd] = 1'b0;
            end
            if (wb1_valid && wb1_rd != 0 && ob[wb1_rd] && ot[wb1_rd] == int'(wb1_tag)) begin
                m_busy[wb1_rd] = 1'b0; m_ldp[wb1_rd] = 1'b0;
            end
            if (iss0_valid && iss0_rd != 0) begin
                m_busy[iss0_rd] = 1'b1; m_ldp[iss0_rd] = iss0_is_load; m_tag[iss0_rd] = t0;
            end
            if (iss1_valid && iss1_rd != 0) begin
                m_busy[iss1_rd] = 1'b1; m_ldp[iss1_rd] = iss1_is_load; m_tag[iss1_rd] = t1;
            end
            m_next = (m_next + int'(iss0_valid) + int'(iss1_valid)) % NT;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush = 0; iss0_valid = 0; iss1_valid = 0; wb0_valid = 0; wb1_valid = 0; ld_rdy_valid = 0;
        iss0_is_load = 0; iss1_is_load = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic issue0(input int rd, input bit ld);
        iss0_valid = 1; iss0_rd = 5'(rd); iss0_is_load = ld;
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("busy_vec", busy_vec, m_busy);
        chk("load_pending_vec", load_pending_vec, m_ldp);
        chk("busy_count", 32'(busy_count), 32'($countones(m_busy)));
        chk("iss0_tag", 32'(iss0_tag), 32'(m_next));
        chk("iss1_tag", 32'(iss1_tag), 32'((m_next + int'(iss0_valid)) % NT));
        chk("inv_bit0", {30'd0, busy_vec[0], load_pending_vec[0]}, 32'd0);
        chk("inv_ldp_subset", load_pending_vec & ~busy_vec, 32'd0);
    end

    initial begin
        tick();
        do_reset();
        cmp_en = 1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_ldp", load_pending_vec, 32'h0);
        chk("rst_count", 32'(busy_count), 32'd0);
        chk("rst_tag", 32'(iss0_tag), 32'd0);

        issue0(5, 1); #1;
        chk("load_tag", 32'(iss0_tag), 32'd0);
        tick(); idle(); #1;
        chk("load_busy", busy_vec, 32'h20);
        chk("load_ldp", load_pending_vec, 32'h20);
        chk("load_count", 32'(busy_count), 32'd1);

        do_reset();
        issue0(3, 0); iss1_valid = 1; iss1_rd = 4; #1;
        chk("dual_tag0", 32'(iss0_tag), 32'd0);
        chk("dual_tag1", 32'(iss1_tag), 32'd1);
        tick(); idle(); #1;
        chk("dual_busy", busy_vec, 32'h18);
        chk("dual_next", 32'(iss0_tag), 32'd2);

        do_reset();
        issue0(7, 0); tick();
        issue0(7, 0); tick(); idle();
        wb0_valid = 1; wb0_rd = 7; wb0_tag = 0; tick(); idle(); #1;
        chk("waw_stale", 32'(busy_vec[7]), 32'd1);
        wb0_valid = 1; wb0_rd = 7; wb0_tag = 1; tick(); idle(); #1;
        chk("waw_match", 32'(busy_vec[7]), 32'd0);

        issue0(9, 1); #1;
        chk("ld_tag", 32'(iss0_tag), 32'd2);
        tick(); idle();
        ld_rdy_valid = 1; ld_rdy_rd = 9; ld_rdy_tag = 2; tick(); idle(); #1;
        chk("ldrdy_ldp", 32'(load_pending_vec[9]), 32'd0);
        chk("ldrdy_busy", 32'(busy_vec[9]), 32'd1);
        wb1_valid = 1; wb1_rd = 9; wb1_tag = 2; tick(); idle(); #1;
        chk("ld_wb", 32'(busy_vec[9]), 32'd0);

        issue0(6, 0); tick(); idle();
        wb0_valid = 1; wb0_rd = 6; wb0_tag = 3; iss1_valid = 1; iss1_rd = 6;
        tick(); idle(); #1;
        chk("coll_busy", 32'(busy_vec[6]), 32'd1);
        wb0_valid = 1; wb0_rd = 6; wb0_tag = 4; tick(); idle(); #1;
        chk("coll_newtag", 32'(busy_vec[6]), 32'd0);
        issue0(0, 0); tick(); idle(); #1;
        chk("rd0_busy", busy_vec, 32'h0);
        chk("rd0_tag", 32'(iss0_tag), 32'd6);

        issue0(10, 0); tick(); idle();
        flush = 1; issue0(2, 0); tick(); idle(); #1;
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_tag", 32'(iss0_tag), 32'd7);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            issue0(1 + i, 0); #1;
            chk("wrap_tag", 32'(iss0_tag), 32'(i % 8));
            tick();
        end
        idle();
        issue0(12, 1); tick();
        rst_n = 0; flush = 1; issue0(13, 1); tick();
        rst_n = 1; idle(); #1;
        chk("mid_rst_busy", busy_vec, 32'h0);
        chk("mid_rst_ldp", load_pending_vec, 32'h0);
        chk("mid_rst_count", 32'(busy_count), 32'd0);
        chk("mid_rst_tag", 32'(iss0_tag), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 39) == 0);
            iss0_valid = $urandom_range(0, 1); iss0_rd = 5'($urandom_range(0, 7)); iss0_is_load = $urandom_range(0, 1);
            iss1_valid = $urandom_range(0, 1); iss1_rd = 5'($urandom_range(0, 7)); iss1_is_load = $urandom_range(0, 1);
            wb0_valid = $urandom_range(0, 1); wb0_rd = 5'($urandom_range(0, 7));
            wb1_valid = $urandom_range(0, 1); wb1_rd = 5'($urandom_range(0, 7));
            ld_rdy_valid = $urandom_range(0, 1); ld_rdy_rd = 5'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            wb0_tag = (r < 7) ? TAG_W'(m_tag[wb0_rd]) : TAG_W'($urandom_range(0, NT - 1));
            r = $urandom_range(0, 9);
            wb1_tag = (r < 7) ? TAG_W'(m_tag[wb1_rd]) : TAG_W'($urandom_range(0, NT - 1));
            r = $urandom_range(0, 9);
            ld_rdy_tag = (r < 7) ? TAG_W'(m_tag[ld_rdy_rd]) : TAG_W'($urandom_range(0, NT - 1));
            tick();
        end
        rst_n = 1; idle(); tick(); tick();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
